// File: rtl/dp_ingress_rr_arbiter_if.sv
// AXI-Stream bundle carrying LANES streams packed side by side (lane i at slice i).
// LANES=1 gives an ordinary single stream.
interface dp_ingress_rr_arbiter_if #(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 9,
  parameter int USER_WIDTH = 97
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES*KEEP_WIDTH-1:0] tkeep;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tready;
  logic [LANES-1:0]            tlast;
  logic [LANES*USER_WIDTH-1:0] tuser;
  logic [LANES*ID_WIDTH-1:0]   tid;
  logic [LANES*DEST_WIDTH-1:0] tdest;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, tid, tdest, input tready);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/dp_ingress_rr_arbiter.sv
// Frame-granular round-robin arbiter sharing one processing pipeline between
// IF_COUNT AXI-Stream ingress ports; grant is locked from arbitration until tlast.
module dp_ingress_rr_arbiter #(
  parameter int IF_COUNT   = 2,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 9,
  parameter int USER_WIDTH = 97,
  parameter int STAT_WIDTH = 32,
  parameter int SEL_WIDTH  = (IF_COUNT > 1) ? $clog2(IF_COUNT) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  dp_ingress_rr_arbiter_if.slave         s_axis,
  dp_ingress_rr_arbiter_if.master        m_axis,
  output logic                           grant_active,
  output logic [SEL_WIDTH-1:0]           grant_index,
  output logic [IF_COUNT*STAT_WIDTH-1:0] frame_count
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state;
  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic [SEL_WIDTH-1:0]  winner;
  logic [SEL_WIDTH-1:0]  next_ptr;
  logic [SEL_WIDTH-1:0]  scan_idx;
  logic                  any_valid;
  logic                  frame_done;
  logic [STAT_WIDTH-1:0] frame_cnt [IF_COUNT];

  // First requester at or after rr_ptr, wrapping around the ports
  always_comb begin : rr_pick
    winner    = rr_ptr;
    any_valid = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < IF_COUNT; k++) begin
      scan_idx = SEL_WIDTH'((int'(rr_ptr) + k) % IF_COUNT);
      if (!any_valid && s_axis.tvalid[scan_idx]) begin
        any_valid = 1'b1;
        winner    = scan_idx;
      end
    end
  end

  assign next_ptr = (grant_index == SEL_WIDTH'(IF_COUNT - 1)) ? '0 : grant_index + 1'b1;

  assign grant_active  = (state == BUSY);
  assign m_axis.tdata  = s_axis.tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
  assign m_axis.tkeep  = s_axis.tkeep[grant_index*KEEP_WIDTH +: KEEP_WIDTH];
  assign m_axis.tuser  = s_axis.tuser[grant_index*USER_WIDTH +: USER_WIDTH];
  assign m_axis.tid    = s_axis.tid[grant_index*ID_WIDTH +: ID_WIDTH];
  assign m_axis.tdest  = s_axis.tdest[grant_index*DEST_WIDTH +: DEST_WIDTH];
  assign m_axis.tlast  = s_axis.tlast[grant_index];
  // tvalid depends only on state and the granted input, never on m_axis.tready
  assign m_axis.tvalid = grant_active & s_axis.tvalid[grant_index];
  assign frame_done    = m_axis.tvalid & m_axis.tready & m_axis.tlast;

  always_comb begin
    s_axis.tready = '0;
    if (grant_active) s_axis.tready[grant_index] = m_axis.tready;
  end

  // Arbitration / frame-lock control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_index <= '0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          grant_index <= winner;
          state       <= BUSY;
        end
        BUSY: if (frame_done) begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completed-frame statistics, wrapping at 2^STAT_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IF_COUNT; i++) frame_cnt[i] <= '0;
    end else if (frame_done) begin
      frame_cnt[grant_index] <= frame_cnt[grant_index] + 1'b1;
    end
  end

  for (genvar i = 0; i < IF_COUNT; i++) begin : g_stat
    assign frame_count[i*STAT_WIDTH +: STAT_WIDTH] = frame_cnt[i];
  end

endmodule

// File: doc/dp_ingress_rr_arbiter.md
Name: dp_ingress_rr_arbiter

Overview:
Packet-granular round-robin arbiter in front of the single data-processing pipeline (demux/parser/mat/deparser, FSM orchestrator). It shares that pipeline between IF_COUNT AXI-Stream ingress interfaces. It grants one whole frame at a time, locks the grant until tlast, and forwards the selected stream unmodified. Per-interface frame counters are exposed for debug and status.

Parameters:
IF_COUNT, 2, number of ingress interfaces (>=1)
DATA_WIDTH, 64, tdata width
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
ID_WIDTH, 1, tid width
DEST_WIDTH, 9, tdest width
USER_WIDTH, 97, tuser width
STAT_WIDTH, 32, width of each per-interface frame counter
SEL_WIDTH, (IF_COUNT>1 ? $clog2(IF_COUNT) : 1), grant index width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_axis_tdata  in  IF_COUNT*DATA_WIDTH  packed ingress data, interface i at slice i
s_axis_tkeep  in  IF_COUNT*KEEP_WIDTH  packed tkeep
s_axis_tvalid  in  IF_COUNT  per-interface valid
s_axis_tready  out  IF_COUNT  per-interface ready
s_axis_tlast  in  IF_COUNT  per-interface last
s_axis_tuser  in  IF_COUNT*USER_WIDTH  packed tuser
s_axis_tid  in  IF_COUNT*ID_WIDTH  packed tid
s_axis_tdest  in  IF_COUNT*DEST_WIDTH  packed tdest
m_axis_tdata  out  DATA_WIDTH  to pipeline
m_axis_tkeep  out  KEEP_WIDTH
m_axis_tvalid  out  1
m_axis_tready  in  1
m_axis_tlast  out  1
m_axis_tuser  out  USER_WIDTH
m_axis_tid  out  ID_WIDTH
m_axis_tdest  out  DEST_WIDTH
grant_active  out  1  high while a frame is locked (BUSY)
grant_index  out  SEL_WIDTH  index of locked interface
frame_count  out  IF_COUNT*STAT_WIDTH  completed frames per interface

Behaviour:
- Reset (rst_n low, async): state=IDLE, rr_ptr=0, grant_index=0, grant_active=0, all frame_count=0. All s_axis_tready=0 and m_axis_tvalid=0 while in reset.
- States: IDLE, BUSY.
- IDLE:
  - m_axis_tvalid=0 and all s_axis_tready=0. m_axis data/side fields are don't-care; drive the slice at grant_index.
  - If any s_axis_tvalid is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping modulo IF_COUNT.
  - Register the winner into grant_index and go to BUSY next cycle. Arbitration latency is 1 cycle.
  - No valid inputs: stay in IDLE.
- BUSY:
  - m_axis_* = slice grant_index of s_axis_* (combinational).
  - s_axis_tready[grant_index]=m_axis_tready. All other s_axis_tready=0.
  - A beat transfers when m_axis_tvalid & m_axis_tready. Beats pass through with zero latency; no buffering.
  - On a transfer with m_axis_tlast=1: frame_count[grant_index] increments, rr_ptr <= (grant_index+1) mod IF_COUNT, state goes to IDLE.
  - The next frame therefore has at least one idle cycle before it. This bubble is intentional: it gives the orchestrator FSM its IDLE cycle.
  - Grant holds regardless of other interfaces' tvalid. The granted input dropping tvalid mid-frame keeps the grant.
- Fairness: an interface that just completed a frame has lowest priority at the next arbitration. With all inputs continuously valid, the grant sequence is 0,1,...,IF_COUNT-1,0,...
- IF_COUNT=1: the arbiter degenerates to pass-through plus the 1-cycle idle between frames. rr_ptr stays 0.
- frame_count wraps modulo 2^STAT_WIDTH; no saturation. Only frames completed with tlast are counted.
- Reset mid-frame: the frame is abandoned. Downstream sees a truncated frame with no tlast; it recovers via its own reset. After reset, arbitration restarts from rr_ptr=0.
- A single-beat frame (tvalid & tlast on the first beat) is handled like any other. It completes in one BUSY cycle when m_axis_tready=1.
- No combinational path from m_axis_tready to m_axis_tvalid.

Test Plan:
1. Reset release; if0 sends a 3-beat frame, m_axis_tready=1 -> grant_active rises 1 cycle after tvalid, 3 beats out with data unchanged, frame_count[0]=1, back in IDLE the cycle after tlast.
2. if0 and if1 both valid at the same cycle, 2 frames each, rr_ptr=0 -> output order if0,if1,if0,if1; each frame boundary followed by exactly 1 idle cycle; frame_count={2,2}.
3. IF_COUNT=3; only if2 and if0 valid, last grant was if0 -> next grant is if2, then if0; if1 is never selected.
4. Backpressure: m_axis_tready low for 4 cycles mid-frame -> s_axis_tready[g]=0, data held, no beat lost or duplicated, other interfaces' tready stay 0.
5. Async reset asserted mid-frame on if1 -> s_axis_tready and m_axis_tvalid drop immediately, counters read 0; after release the first grant goes to the lowest valid index.
6. STAT_WIDTH=4; 17 single-beat frames on if0 -> frame_count[0]=1 (wrap).
